mini_cmd_exec: RTL and testbench

Responder side of the miniature-processor command interface. Accepts one command per start/done handshake, reads operands from an internal 32x16 signed register file, executes, writes back, and pulses done. The bench initiator issues the next command on done. Display-type commands drive result ports instead of printing.

---
 rtl/mini_cpu_pkg.sv | 55 +++++
 rtl/mini_regfile.sv | 31 +++
 rtl/mini_cmd_exec.sv | 122 ++++++++++++
 tb/tb_mini_cmd_exec.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared types, opcodes and ALU helper for the mini command executor.
package mini_cpu_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned SHAMT_W = 4;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] OP_LOADI = 3'b000;
  localparam logic [OP_W-1:0] OP_DISP  = 3'b001;
  localparam logic [OP_W-1:0] OP_DISP2 = 3'b010;
  localparam logic [OP_W-1:0] OP_ADDI  = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b101;
  localparam logic [OP_W-1:0] OP_AND   = 3'b110;
  localparam logic [OP_W-1:0] OP_SLL   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  // Command fields that must survive past the accepting edge
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  function automatic logic is_disp(input logic [OP_W-1:0] op);
    return (op == OP_DISP) || (op == OP_DISP2);
  endfunction

  // Two's complement, wrapping; shifts use only the low immediate bits
  function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0]   op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] imm);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_LOADI: r = imm;
      OP_ADDI:  r = a + imm;
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_SLL:   r = a << imm[SHAMT_W-1:0];
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mini_regfile.sv
// 32x16 register file: two combinational reads, one synchronous write, R0 hardwired to zero.
module mini_regfile
  import mini_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/mini_cmd_exec.sv
// Command responder: accept on start, read operands, execute, write back, pulse done.
module mini_cmd_exec
  import mini_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   cmd,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  input  logic [ADDR_W-1:0] write,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

  logic [DATA_W-1:0] rf_a_c;
  logic [DATA_W-1:0] rf_b_c;
  logic              we_c;

  mini_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (read1),
    .raddr_b_i (read2),
    .rdata_a_o (rf_a_c),
    .rdata_b_o (rf_b_c),
    .we_i      (we_c),
    .waddr_i   (cmd_q.rd),
    .wdata_i   (result_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  // Busy is re-armed by an accept in the done cycle, so held start runs back-to-back
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    we_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          cmd_d   = '{op: cmd, rd: write, imm: data};
          op_a_d  = rf_a_c;
          op_b_d  = rf_b_c;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy_d   = 1'b1;
        result_d = alu(cmd_q.op, op_a_q, op_b_q, cmd_q.imm);
        state_d  = S_WB;
      end
      S_WB: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        we_c    = !is_disp(cmd_q.op);
        if (is_disp(cmd_q.op)) begin
          rd_valid_d  = 1'b1;
          rd_data_a_d = op_a_q;
          rd_data_b_d = (cmd_q.op == OP_DISP2) ? op_b_q : '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_mini_cmd_exec.sv
// Directed table-driven bench for mini_cmd_exec plus handshake and reset sequences.
module tb_mini_cmd_exec;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  cmd;
  logic [4:0]  read1, read2, write;
  logic [15:0] data;
  logic        busy, done, rd_valid;
  logic [15:0] rd_data_a, rd_data_b;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  w;
    logic [15:0] imm;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl[$];

  mini_cmd_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .read1     (read1),
    .read2     (read2),
    .write     (write),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .rd_valid  (rd_valid),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] w, input logic [15:0] imm,
                              input logic [15:0] ea, input logic [15:0] eb);
    vec_t v;
    v.op = op; v.r1 = r1; v.r2 = r2; v.w = w; v.imm = imm; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd = v.op; read1 = v.r1; read2 = v.r2; write = v.w; data = v.imm;
  endtask

  // Issue one command, wait (bounded) for done, check the done cycle
  task automatic do_row(input vec_t v, input string tag);
    int  lat;
    logic disp;
    disp = (v.op == OP_DISP) || (v.op == OP_DISP2);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " busy@done"}, 32'(busy), 32'd1);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(disp));
    if (disp) begin
      last_a = v.ea;
      last_b = v.eb;
    end
    check({tag, " rd_data_a"}, 32'(rd_data_a), 32'(last_a));
    check({tag, " rd_data_b"}, 32'(rd_data_b), 32'(last_b));
  endtask

  initial begin
    int ndone;
    logic [15:0] mask;

    rst_n = 1'b0; start = 1'b0;
    cmd = '0; read1 = '0; read2 = '0; write = '0; data = '0;

    tbl.push_back(mk(OP_LOADI, 5'd0, 5'd0, 5'd1, 16'd17,    16'd0,     16'd0));
    tbl.push_back(mk(OP_ADDI,  5'd1, 5'd0, 5'd2, 16'hFFF7,  16'd0,     16'd0));
    tbl.push_back(mk(OP_ADD,   5'd1, 5'd2, 5'd3, 16'h1234,  16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP2, 5'd2, 5'd3, 5'd0, 16'd0,     16'd8,     16'd25));
    tbl.push_back(mk(OP_SLL,   5'd3, 5'd0, 5'd5, 16'd3,     16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd5, 5'd3, 5'd0, 16'd0,     16'd200,   16'd0));
    tbl.push_back(mk(OP_SUB,   5'd1, 5'd2, 5'd4, 16'd0,     16'd0,     16'd0));
    tbl.push_back(mk(OP_SLL,   5'd4, 5'd0, 5'd4, 16'd9,     16'd0,     16'd0));
    tbl.push_back(mk(OP_AND,   5'd5, 5'd4, 5'd6, 16'd0,     16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd6, 5'd0, 5'd0, 16'd0,     16'd0,     16'd0));
    tbl.push_back(mk(OP_LOADI, 5'd0, 5'd0, 5'd7, 16'hFFFF,  16'd0,     16'd0));
    tbl.push_back(mk(OP_AND,   5'd7, 5'd5, 5'd6, 16'd0,     16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd6, 5'd0, 5'd0, 16'd0,     16'd200,   16'd0));
    tbl.push_back(mk(OP_DISP2, 5'd4, 5'd7, 5'd0, 16'd0,     16'h1200,  16'hFFFF));
    tbl.push_back(mk(OP_LOADI, 5'd0, 5'd0, 5'd1, 16'h7FFF,  16'd0,     16'd0));
    tbl.push_back(mk(OP_ADDI,  5'd1, 5'd0, 5'd1, 16'd1,     16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd1, 5'd0, 5'd0, 16'd0,     16'h8000,  16'd0));
    tbl.push_back(mk(OP_LOADI, 5'd0, 5'd0, 5'd2, 16'd1,     16'd0,     16'd0));
    tbl.push_back(mk(OP_SLL,   5'd2, 5'd0, 5'd8, 16'hFFF3,  16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd8, 5'd0, 5'd0, 16'd0,     16'd8,     16'd0));
    tbl.push_back(mk(OP_LOADI, 5'd0, 5'd0, 5'd0, 16'd55,    16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP,  5'd0, 5'd8, 5'd0, 16'd0,     16'd0,     16'd0));
    tbl.push_back(mk(OP_ADD,   5'd0, 5'd0, 5'd1, 16'd9,     16'd0,     16'd0));
    tbl.push_back(mk(OP_DISP2, 5'd1, 5'd0, 5'd0, 16'd0,     16'd0,     16'd0));

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data_a", 32'(rd_data_a), 32'd0);
    check("reset rd_data_b", 32'(rd_data_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) do_row(tbl[i], $sformatf("row%0d", i));

    // done is one cycle wide and busy falls with it
    @(posedge clk);
    #1;
    check("done width", 32'(done), 32'd0);
    check("busy after done", 32'(busy), 32'd0);

    // start during EXEC/WB is ignored: second LOADI R9=77 must not land
    @(negedge clk);
    drive(mk(OP_LOADI, 5'd0, 5'd0, 5'd9, 16'd11, 16'd0, 16'd0));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = 16'd77;
    @(posedge clk);
    #1 check("busy in EXEC", 32'(busy), 32'd1);
    @(posedge clk);
    #1 check("ignored-start done", 32'(done), 32'd1);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("ignored-start extra done", 32'(ndone), 32'd0);
    check("ignored-start busy idle", 32'(busy), 32'd0);
    do_row(mk(OP_DISP, 5'd9, 5'd0, 5'd0, 16'd0, 16'd11, 16'd0), "disp R9");

    // start held high: three ADDI R10+=1 back-to-back, done every 3 cycles
    @(negedge clk);
    drive(mk(OP_ADDI, 5'd10, 5'd0, 5'd10, 16'd1, 16'd0, 16'd0));
    start = 1'b1;
    ndone = 0;
    mask  = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        mask[k] = 1'b1;
      end
      if (k == 7) start = 1'b0;
    end
    check("held-start done count", 32'(ndone), 32'd3);
    check("held-start done slots", 32'(mask), 32'h248);
    do_row(mk(OP_DISP, 5'd10, 5'd0, 5'd0, 16'd0, 16'd3, 16'd0), "disp R10");

    // Async reset in the middle of LOADI R3=99
    @(negedge clk);
    drive(mk(OP_LOADI, 5'd0, 5'd0, 5'd3, 16'd99, 16'd0, 16'd0));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset rd_valid", 32'(rd_valid), 32'd0);
    check("midreset rd_data_a", 32'(rd_data_a), 32'd0);
    check("midreset rd_data_b", 32'(rd_data_b), 32'd0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midreset no done", 32'(ndone), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
    do_row(mk(OP_DISP,  5'd3, 5'd0,  5'd0, 16'd0, 16'd0, 16'd0), "post-reset R3");
    do_row(mk(OP_DISP2, 5'd7, 5'd10, 5'd0, 16'd0, 16'd0, 16'd0), "post-reset R7/R10");
    do_row(mk(OP_DISP2, 5'd5, 5'd9,  5'd0, 16'd0, 16'd0, 16'd0), "post-reset R5/R9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
